// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
package seg_pkg;

    localparam int DIGITS = 8;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // Digit 0 occupies the most significant nibble.
    function automatic logic [31:0] put_nibble(
        input logic [31:0] v,
        input logic [2:0]  idx,
        input logic [3:0]  nib
    );
        logic [4:0] sh;
        sh = {3'd7 - idx, 2'b00};
        return (v & ~(32'hF << sh)) | ({28'd0, nib} << sh);
    endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_to_hex.sv
// Combinational seven-segment pattern to hex nibble decoder.
module seg7_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       bad
);

    always_comb begin
        nibble = 4'h0;
        bad    = 1'b0;
        case (seg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: bad    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Reassembles a 32-bit value from an 8-digit seven-segment scan stream.
// Define SEG_ACTIVE_LOW_EN for common-anode (inverted) segment buses.
module seg_scan_decoder
    import seg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        which,
    input  logic [7:0]        seg,
    input  logic              enable,
    output logic [31:0]       value,
    output logic [DIGITS-1:0] dp,
    output logic              value_valid,
    output logic              frame_err,
    output logic              blank
);

    logic [7:0]        seg_in;
    logic [3:0]        nib;
    logic              dec_bad;

`ifdef SEG_ACTIVE_LOW_EN
    assign seg_in = ~seg;
`else
    assign seg_in = seg;
`endif

    seg7_to_hex u_dec (
        .seg    (seg_in[6:0]),
        .nibble (nib),
        .bad    (dec_bad)
    );

    state_e            state_q, state_d;
    logic [2:0]        exp_q, exp_d;
    logic [31:0]       sh_val_q, sh_val_d;
    logic [DIGITS-1:0] sh_dp_q, sh_dp_d;
    logic              bad_q, bad_d;
    logic [31:0]       value_q, value_d;
    logic [DIGITS-1:0] dp_q, dp_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              blank_q, blank_d;

    logic [31:0]       ins_val;
    logic [DIGITS-1:0] ins_dp;
    logic              ins_bad;
    logic [31:0]       start_val;
    logic [DIGITS-1:0] start_dp;

    // Candidate shadow contents if the current sample is accepted.
    always_comb begin
        ins_val        = put_nibble(sh_val_q, which, nib);
        ins_dp         = sh_dp_q;
        ins_dp[which]  = seg_in[7];
        ins_bad        = bad_q | dec_bad;
        start_val      = put_nibble(32'd0, 3'd0, nib);
        start_dp       = {{(DIGITS-1){1'b0}}, seg_in[7]};
    end

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        sh_val_d = sh_val_q;
        sh_dp_d  = sh_dp_q;
        bad_d    = bad_q;
        value_d  = value_q;
        dp_d     = dp_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        blank_d  = ~enable;

        if (!enable) begin
            state_d  = IDLE;
            exp_d    = 3'd0;
            sh_val_d = 32'd0;
            sh_dp_d  = '0;
            bad_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (which == 3'd0) begin
                        state_d  = SCAN;
                        exp_d    = 3'd1;
                        sh_val_d = start_val;
                        sh_dp_d  = start_dp;
                        bad_d    = dec_bad;
                    end
                end
                SCAN: begin
                    if (which == exp_q) begin
                        if (which == 3'd7) begin
                            state_d = IDLE;
                            exp_d   = 3'd0;
                            if (!ins_bad) begin
                                value_d = ins_val;
                                dp_d    = ins_dp;
                                valid_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else begin
                            sh_val_d = ins_val;
                            sh_dp_d  = ins_dp;
                            bad_d    = ins_bad;
                            exp_d    = exp_q + 3'd1;
                        end
                    end else if (which == exp_q - 3'd1) begin
                        // Prescaled drivers hold a digit for several cycles.
                        sh_val_d = ins_val;
                        sh_dp_d  = ins_dp;
                        bad_d    = ins_bad;
                    end else begin
                        err_d = 1'b1;
                        if (which == 3'd0) begin
                            exp_d    = 3'd1;
                            sh_val_d = start_val;
                            sh_dp_d  = start_dp;
                            bad_d    = dec_bad;
                        end else begin
                            state_d = IDLE;
                            exp_d   = 3'd0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    exp_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            exp_q    <= 3'd0;
            sh_val_q <= 32'd0;
            sh_dp_q  <= '0;
            bad_q    <= 1'b0;
            value_q  <= 32'd0;
            dp_q     <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            blank_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            sh_val_q <= sh_val_d;
            sh_dp_q  <= sh_dp_d;
            bad_q    <= bad_d;
            value_q  <= value_d;
            dp_q     <= dp_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            blank_q  <= blank_d;
        end
    end

    assign value       = value_q;
    assign dp          = dp_q;
    assign value_valid = valid_q;
    assign frame_err   = err_q;
    assign blank       = blank_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder with a behavioural frame model.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  which;
    logic [7:0]  seg;
    logic        enable;
    logic [31:0] value;
    logic [7:0]  dp;
    logic        value_valid;
    logic        frame_err;
    logic        blank;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_scan_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .which       (which),
        .seg         (seg),
        .enable      (enable),
        .value       (value),
        .dp          (dp),
        .value_valid (value_valid),
        .frame_err   (frame_err),
        .blank       (blank)
    );

    localparam logic [6:0] PAT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference model: list of received digits plus the index wanted next.
    int          m_next;
    logic [3:0]  m_dig [8];
    logic        m_dpb [8];
    bit          m_bad;
    logic [31:0] m_value;
    logic [7:0]  m_dp;
    bit          m_vv, m_fe, m_blank;

    function automatic int lookup(input logic [6:0] p);
        for (int k = 0; k < 16; k++)
            if (PAT[k] == p) return k;
        return -1;
    endfunction

    function automatic logic [7:0] pat(input int n, input bit d);
        logic [6:0] p;
        p = PAT[n];
        return {d, p};
    endfunction

    task automatic model_reset();
        m_next  = -1;
        m_bad   = 0;
        m_value = 32'd0;
        m_dp    = 8'd0;
        m_vv    = 0;
        m_fe    = 0;
        m_blank = 1;
    endtask

    task automatic model_step(input logic [2:0] w, input logic [7:0] s,
                              input bit e);
        int k;
        bit b;
        k = lookup(s[6:0]);
        b = (k < 0);
        m_vv = 0;
        m_fe = 0;
        m_blank = !e;
        if (!e) begin
            m_next = -1;
        end else if (m_next < 0) begin
            if (w == 0) begin
                m_dig[0] = k[3:0]; m_dpb[0] = s[7];
                m_bad = b; m_next = 1;
            end
        end else if (int'(w) == m_next) begin
            m_dig[w] = k[3:0]; m_dpb[w] = s[7];
            m_bad = m_bad | b;
            if (w == 7) begin
                if (!m_bad) begin
                    for (int i = 0; i < 8; i++) begin
                        m_value[31-4*i -: 4] = m_dig[i];
                        m_dp[i] = m_dpb[i];
                    end
                    m_vv = 1;
                end else begin
                    m_fe = 1;
                end
                m_next = -1;
            end else begin
                m_next++;
            end
        end else if (int'(w) == m_next - 1) begin
            m_dig[w] = k[3:0]; m_dpb[w] = s[7];
            m_bad = m_bad | b;
        end else begin
            m_fe = 1;
            if (w == 0) begin
                m_dig[0] = k[3:0]; m_dpb[0] = s[7];
                m_bad = b; m_next = 1;
            end else begin
                m_next = -1;
            end
        end
    endtask

    task automatic step(input logic [2:0] w, input logic [7:0] s,
                        input bit e);
        which = w;
`ifdef SEG_ACTIVE_LOW_EN
        seg = ~s;
`else
        seg = s;
`endif
        enable = e;
        @(posedge clk);
        #1;
        model_step(w, s, e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        which = 3'd0;
        seg = 8'h00;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if ({value, dp, value_valid, frame_err, blank} !== {40'd0, 3'b001}) begin
            errors++;
            $display("FAIL reset_state: got %h/%h/%b%b%b want 0/0/001",
                     value, dp, value_valid, frame_err, blank);
        end
        rst = 1'b0;
    endtask

    task automatic test_clean();
        int pulses;
        pulses = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) begin
                step(3'(i), pat(f == 0 ? i + 1 : (i + 9) % 16, 1'b0), 1'b1);
                if (value_valid) pulses++;
                if (i == 7) begin
                    checks++;
                    if (value_valid !== 1'b1 ||
                        value !== (f == 0 ? 32'h12345678 : 32'h9ABCDEF0)) begin
                        errors++;
                        $display("FAIL clean_commit%0d: got %h vv=%b",
                                 f, value, value_valid);
                    end
                end
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL clean_pulses: got %0d want 2", pulses);
        end
        checks++;
        if (blank !== 1'b0) begin
            errors++;
            $display("FAIL clean_blank: got %b want 0", blank);
        end
    endtask

    task automatic test_bad_code();
        int errs;
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            step(3'(i), (i == 3) ? 8'h00 : pat(i + 1, 1'b0), 1'b1);
            if (frame_err) errs++;
            if (i == 7) begin
                checks++;
                if (frame_err !== 1'b1 || value_valid !== 1'b0 ||
                    value !== 32'h9ABCDEF0) begin
                    errors++;
                    $display("FAIL bad_code: got %h fe=%b vv=%b want 9abcdef0 fe=1 vv=0",
                             value, frame_err, value_valid);
                end
            end
        end
        checks++;
        if (errs != 1) begin
            errors++;
            $display("FAIL bad_code_count: got %0d want 1", errs);
        end
    endtask

    task automatic test_skip();
        int seq [4] = '{0, 1, 2, 4};
        for (int i = 0; i < 4; i++) begin
            step(3'(seq[i]), pat(i, 1'b0), 1'b1);
            checks++;
            if (frame_err !== (i == 3)) begin
                errors++;
                $display("FAIL skip_err%0d: got %b want %b", i, frame_err, i == 3);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(3'(i), pat(8 - i, 1'b0), 1'b1);
            if (i == 0) begin
                checks++;
                if (frame_err !== 1'b0) begin
                    errors++;
                    $display("FAIL skip_err_len: got %b want 0", frame_err);
                end
            end
        end
        checks++;
        if (value_valid !== 1'b1 || value !== 32'h87654321) begin
            errors++;
            $display("FAIL skip_recover: got %h vv=%b want 87654321 vv=1",
                     value, value_valid);
        end
    endtask

    task automatic test_enable_drop();
        for (int i = 0; i < 5; i++) step(3'(i), pat(5, 1'b0), 1'b1);
        step(3'd5, pat(5, 1'b0), 1'b0);
        checks++;
        if (blank !== 1'b1 || frame_err !== 1'b0 || value !== 32'h87654321) begin
            errors++;
            $display("FAIL drop_blank: got blank=%b fe=%b %h want 1 0 87654321",
                     blank, frame_err, value);
        end
        step(3'd6, pat(5, 1'b0), 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(3'(i), pat(2 * i + 1, 1'b0), 1'b1);
            if (i == 0) begin
                checks++;
                if (blank !== 1'b0 || frame_err !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_reenable: got blank=%b fe=%b want 0 0",
                             blank, frame_err);
                end
            end
        end
        checks++;
        if (value_valid !== 1'b1 || value !== 32'h13579BDF) begin
            errors++;
            $display("FAIL drop_commit: got %h vv=%b want 13579bdf vv=1",
                     value, value_valid);
        end
    endtask

    task automatic test_prescaled();
        int dig [8] = '{10, 11, 12, 13, 14, 15, 0, 9};
        int pulses;
        int errs;
        pulses = 0;
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            for (int h = 0; h < 2; h++) begin
                step(3'(i), pat(dig[i], i == 2), 1'b1);
                if (value_valid) pulses++;
                if (frame_err) errs++;
            end
        end
        checks++;
        if (pulses != 1 || errs != 0) begin
            errors++;
            $display("FAIL prescaled_pulses: got vv=%0d fe=%0d want 1 0",
                     pulses, errs);
        end
        checks++;
        if (value !== 32'hABCDEF09 || dp !== 8'h04) begin
            errors++;
            $display("FAIL prescaled_value: got %h dp=%h want abcdef09 dp=04",
                     value, dp);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(3'(i), pat(i, 1'b1), 1'b1);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({value, dp, value_valid, frame_err, blank} !== {40'd0, 3'b001}) begin
            errors++;
            $display("FAIL async_reset: got %h/%h/%b%b%b want 0/0/001",
                     value, dp, value_valid, frame_err, blank);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 3; i < 8; i++) begin
            step(3'(i), pat(i, 1'b1), 1'b1);
            checks++;
            if (value_valid !== 1'b0 || frame_err !== 1'b0) begin
                errors++;
                $display("FAIL lost_frame%0d: got vv=%b fe=%b want 0 0",
                         i, value_valid, frame_err);
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] q [$];
        logic [7:0]  s;
        logic [2:0]  w;
        bit          e;
        int          mode, hold, badpos, skippos, droppos;
        for (int f = 0; f < 80; f++) begin
            mode    = $urandom_range(0, 5);
            hold    = (mode == 1) ? 2 : 1;
            badpos  = (mode == 2) ? $urandom_range(0, 7) : -1;
            skippos = (mode == 3) ? $urandom_range(1, 6) : -1;
            droppos = (mode == 4) ? $urandom_range(0, 7) : -1;
            if (mode == 5) begin
                for (int c = 0; c < 6; c++) begin
                    w = 3'($urandom_range(0, 7));
                    s = ($urandom_range(0, 3) == 0) ? 8'h7E :
                        pat($urandom_range(0, 15), 1'($urandom_range(0, 1)));
                    e = ($urandom_range(0, 7) != 0);
                    q.push_back({e, w, s});
                end
            end else begin
                for (int d = 0; d < 8; d++) begin
                    for (int h = 0; h < hold; h++) begin
                        w = (d == skippos) ? 3'(d + 1) : 3'(d);
                        s = (d == badpos) ? 8'h00 :
                            pat($urandom_range(0, 15), 1'($urandom_range(0, 1)));
                        e = (d != droppos);
                        q.push_back({e, w, s});
                    end
                end
            end
        end
        while (q.size() > 0) begin
            logic [11:0] ent;
            ent = q.pop_front();
            step(ent[10:8], ent[7:0], ent[11]);
            checks++;
            if ({value, dp, value_valid, frame_err, blank} !==
                {m_value, m_dp, m_vv, m_fe, m_blank}) begin
                errors++;
                $display("FAIL random: got %h/%h/%b%b%b want %h/%h/%b%b%b",
                         value, dp, value_valid, frame_err, blank,
                         m_value, m_dp, m_vv, m_fe, m_blank);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_bad_code();
        test_skip();
        test_enable_drop();
        test_prescaled();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
